// File: rtl/parallax_pkg.sv
// Shared types and helpers for the parallax scroller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   scroll_state_t : RUN / FROZEN scroller state
//   DEFAULT_WRAP   : default offset modulus (sprite period in pixels)
//   wrap_add()     : modular add that never yields a value >= wrap
package parallax_pkg;

  typedef enum logic {RUN, FROZEN} scroll_state_t;

  localparam int DEFAULT_WRAP = 640;

  // Add step to offset and fold back into [0, wrap). Callers keep
  // offset < wrap and step <= 2, so a single subtraction is enough.
  function automatic int wrap_add(input int offset, input int step, input int wrap);
    int sum;
    sum = offset + step;
    return (sum >= wrap) ? (sum - wrap) : sum;
  endfunction

endpackage

// File: rtl/parallax_scroller_scroll_layer.sv
// One scroll layer: move prescaler, wrapped offset register, wrap pulse.
// Latency: a tick sampled at edge k updates offset/wrap after edge k.
// Backpressure: none; tick_en is a qualified move, clr/pre_clr override it.
//   clk, reset : clock, synchronous active-high reset
//   tick_en    : qualified move pulse (RUN, no restart/collision)
//   clr        : zero offset, prescaler and wrap pulse
//   pre_clr    : zero only the prescaler (used when leaving FROZEN)
//   step2      : step by 2 instead of 1
//   div        : move pulses per step; 0 keeps the layer stationary
//   offset     : current offset, always 0..WRAP-1
//   wrap       : one-cycle pulse on a wrapping step
module scroll_layer
  import parallax_pkg::*;
#(
  parameter int OFFSET_W = 12,
  parameter int WRAP     = DEFAULT_WRAP,
  parameter int DIV_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick_en,
  input  logic                clr,
  input  logic                pre_clr,
  input  logic                step2,
  input  logic [DIV_W-1:0]    div,
  output logic [OFFSET_W-1:0] offset,
  output logic                wrap
);

  logic [DIV_W-1:0]    presc;
  logic [DIV_W:0]      presc_inc;
  logic [OFFSET_W:0]   sum_wide;
  logic                wrap_hit;
  logic [OFFSET_W-1:0] offset_next;
  logic                step_due;

  // Carry bit kept so a full prescaler still compares correctly.
  assign presc_inc = {1'b0, presc} + {{DIV_W{1'b0}}, 1'b1};

  // '>=' rather than '==' so that lowering div below the running count
  // makes the very next move step the layer.
  assign step_due = (div != '0) && (presc_inc >= {1'b0, div});

  // One bit wider than the offset so offset+2 near the top cannot alias.
  assign sum_wide    = {1'b0, offset} + {{(OFFSET_W-1){1'b0}}, step2, ~step2};
  assign wrap_hit    = (sum_wide >= (OFFSET_W+1)'(WRAP));
  assign offset_next = OFFSET_W'(wrap_add(32'(offset), step2 ? 2 : 1, WRAP));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      presc  <= '0;
      offset <= '0;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (pre_clr) begin
        presc <= '0;
      end else if (tick_en) begin
        if (div == '0) begin
          presc <= '0;
        end else if (step_due) begin
          presc  <= '0;
          offset <= offset_next;
          wrap   <= wrap_hit;
        end else begin
          presc <= presc_inc[DIV_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/parallax_scroller.sv
// Multi-layer scroll-offset generator: RUN/FROZEN control plus NUM_LAYERS layers.
// Latency: a move sampled at edge k shows on layer_offset/layer_wrap after edge k.
// Backpressure: none; collision freezes all layers, resume/restart release them.
//   clk, reset   : clock, synchronous active-high reset
//   move         : single-cycle game tick
//   collision    : freezes scrolling (level or pulse)
//   resume       : leaves FROZEN when collision is low
//   restart      : zero all offsets and return to RUN
//   boost        : step of 2 instead of 1
//   layer_div    : per-layer divisor, layer i at [i*DIV_W +: DIV_W]
//   layer_offset : per-layer offset, layer i at [i*OFFSET_W +: OFFSET_W]
//   layer_wrap   : per-layer one-cycle wrap pulse
//   frozen       : high while in FROZEN
// WRAP must stay below 2**OFFSET_W - 2 so offset+2 fits the widened sum.
module parallax_scroller
  import parallax_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int OFFSET_W   = 12,
  parameter int WRAP       = DEFAULT_WRAP,
  parameter int DIV_W      = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           move,
  input  logic                           collision,
  input  logic                           resume,
  input  logic                           restart,
  input  logic                           boost,
  input  logic [NUM_LAYERS*DIV_W-1:0]    layer_div,
  output logic [NUM_LAYERS*OFFSET_W-1:0] layer_offset,
  output logic [NUM_LAYERS-1:0]          layer_wrap,
  output logic                           frozen
);

  scroll_state_t state;
  scroll_state_t state_next;
  logic          tick_en;
  logic          pre_clr;

  // Priority: restart > collision > resume > move (reset handled in the flops).
  always_comb begin
    state_next = state;
    tick_en    = 1'b0;
    pre_clr    = 1'b0;
    if (restart) begin
      state_next = RUN;
    end else if (collision) begin
      state_next = FROZEN;
    end else if (state == FROZEN) begin
      // A move arriving with resume is dropped; counting restarts from zero.
      if (resume) begin
        state_next = RUN;
        pre_clr    = 1'b1;
      end
    end else begin
      tick_en = move;
    end
  end

  // frozen is registered together with the state so it always equals
  // (state == FROZEN) without an extra cycle of lag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      frozen <= 1'b0;
    end else begin
      state  <= state_next;
      frozen <= (state_next == FROZEN);
    end
  end

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    scroll_layer #(
      .OFFSET_W (OFFSET_W),
      .WRAP     (WRAP),
      .DIV_W    (DIV_W)
    ) u_layer (
      .clk     (clk),
      .reset   (reset),
      .tick_en (tick_en),
      .clr     (restart),
      .pre_clr (pre_clr),
      .step2   (boost),
      .div     (layer_div[i*DIV_W +: DIV_W]),
      .offset  (layer_offset[i*OFFSET_W +: OFFSET_W]),
      .wrap    (layer_wrap[i])
    );
  end

endmodule

// File: tb/tb_parallax_scroller.sv
// Self-checking bench for parallax_scroller.
// Each driven cycle pushes the reference model's expected outputs to a
// scoreboard queue; the owning test pops and compares after the edge.
module tb_parallax_scroller;

  localparam int NL   = 3;
  localparam int OW   = 12;
  localparam int DW   = 4;
  localparam int WRAP = 640;

  logic              clk = 1'b0;
  logic              reset;
  logic              move, collision, resume, restart, boost;
  logic [NL*DW-1:0]  layer_div;
  logic [NL*OW-1:0]  layer_offset;
  logic [NL-1:0]     layer_wrap;
  logic              frozen;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [NL*OW-1:0] off;
    logic [NL-1:0]    wr;
    logic             fr;
  } exp_t;

  exp_t sb[$];

  // Reference model state.
  int m_off[NL];
  int m_pre[NL];
  bit m_froz;

  parallax_scroller #(
    .NUM_LAYERS (NL),
    .OFFSET_W   (OW),
    .WRAP       (WRAP),
    .DIV_W      (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .move         (move),
    .collision    (collision),
    .resume       (resume),
    .restart      (restart),
    .boost        (boost),
    .layer_div    (layer_div),
    .layer_offset (layer_offset),
    .layer_wrap   (layer_wrap),
    .frozen       (frozen)
  );

  always #5 clk = ~clk;

  function automatic exp_t snap(input logic [NL-1:0] w);
    exp_t e;
    for (int i = 0; i < NL; i++) e.off[i*OW +: OW] = OW'(m_off[i]);
    e.wr = w;
    e.fr = m_froz;
    return e;
  endfunction

  // Drive one cycle, advance the model, push its expectation, then wait
  // until just after the edge so the outputs can be sampled.
  task automatic step(input logic mv, input logic col, input logic res,
                      input logic rst_, input logic bst);
    logic [NL-1:0] w;
    int d, n;
    w = '0;
    move = mv; collision = col; resume = res; restart = rst_; boost = bst;
    if (rst_) begin
      for (int i = 0; i < NL; i++) begin m_off[i] = 0; m_pre[i] = 0; end
      m_froz = 0;
    end else if (col) begin
      m_froz = 1;
    end else if (m_froz) begin
      if (res) begin
        m_froz = 0;
        for (int i = 0; i < NL; i++) m_pre[i] = 0;
      end
    end else if (mv) begin
      for (int i = 0; i < NL; i++) begin
        d = int'(layer_div[i*DW +: DW]);
        if (d == 0) m_pre[i] = 0;
        else if (m_pre[i] + 1 >= d) begin
          m_pre[i] = 0;
          n = m_off[i] + (bst ? 2 : 1);
          if (n >= WRAP) begin m_off[i] = n - WRAP; w[i] = 1'b1; end
          else m_off[i] = n;
        end else m_pre[i] = m_pre[i] + 1;
      end
    end
    sb.push_back(snap(w));
    @(posedge clk); #1;
    move = 0; collision = 0; resume = 0; restart = 0; boost = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NL; i++) begin m_off[i] = 0; m_pre[i] = 0; end
    m_froz = 0;
    sb.push_back(snap('0));
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    e = sb.pop_front();
    tests_run++;
    if (layer_offset !== e.off || layer_wrap !== e.wr || frozen !== e.fr) begin
      tests_failed++;
      $display("FAIL reset: off=%h wrap=%b frz=%b want off=%h wrap=%b frz=%b",
               layer_offset, layer_wrap, frozen, e.off, e.wr, e.fr);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    layer_div = 12'h421;   // layer0=1, layer1=2, layer2=4
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, 0, 0);
      e = sb.pop_front();
      tests_run++;
      if (layer_offset !== e.off || layer_wrap !== e.wr || frozen !== e.fr) begin
        tests_failed++;
        $display("FAIL basic[%0d]: off=%h wrap=%b frz=%b want off=%h wrap=%b frz=%b",
                 k, layer_offset, layer_wrap, frozen, e.off, e.wr, e.fr);
      end
    end
    tests_run++;
    if (layer_offset !== {12'd1, 12'd2, 12'd5} || frozen !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_final: off=%h frz=%b want off=%h frz=0",
               layer_offset, frozen, {12'd1, 12'd2, 12'd5});
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    layer_div = 12'h111;
    step(0, 0, 0, 1, 0);
    void'(sb.pop_front());
    for (int k = 0; k < 640; k++) begin
      step(1, 0, 0, 0, 0);
      e = sb.pop_front();
      tests_run++;
      if (layer_offset !== e.off || layer_wrap !== e.wr || layer_offset[OW-1:0] >= 12'd640) begin
        tests_failed++;
        $display("FAIL wrap_seq[%0d]: off=%h wrap=%b want off=%h wrap=%b",
                 k, layer_offset, layer_wrap, e.off, e.wr);
      end
      if (k == 638) begin
        tests_run++;
        if (layer_offset[OW-1:0] !== 12'd639 || layer_wrap[0] !== 1'b0) begin
          tests_failed++;
          $display("FAIL wrap_639: off0=%0d wrap0=%b want 639/0",
                   layer_offset[OW-1:0], layer_wrap[0]);
        end
      end
    end
    tests_run++;
    if (layer_offset[OW-1:0] !== 12'd0 || layer_wrap[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_zero: off0=%0d wrap0=%b want 0/1", layer_offset[OW-1:0], layer_wrap[0]);
    end
    step(0, 0, 0, 0, 0);
    e = sb.pop_front();
    tests_run++;
    if (layer_wrap !== 3'b000 || layer_offset !== e.off) begin
      tests_failed++;
      $display("FAIL wrap_pulse_len: wrap=%b off=%h want wrap=000 off=%h",
               layer_wrap, layer_offset, e.off);
    end
  endtask

  task automatic test_boost();
    exp_t e;
    layer_div = 12'h111;
    step(0, 0, 0, 1, 0);
    void'(sb.pop_front());
    for (int k = 0; k < 639; k++) begin step(1, 0, 0, 0, 0); void'(sb.pop_front()); end
    step(1, 0, 0, 0, 1);
    e = sb.pop_front();
    tests_run++;
    if (layer_offset !== e.off || layer_wrap !== e.wr ||
        layer_offset[OW-1:0] !== 12'd1 || layer_wrap[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL boost_639: off=%h wrap=%b want off=%h wrap=%b (off0=1)",
               layer_offset, layer_wrap, e.off, e.wr);
    end
    for (int k = 0; k < 636; k++) begin step(1, 0, 0, 0, 0); void'(sb.pop_front()); end
    step(1, 0, 0, 0, 1);
    e = sb.pop_front();
    tests_run++;
    if (layer_offset !== e.off || layer_wrap !== e.wr ||
        layer_offset[OW-1:0] !== 12'd639 || layer_wrap[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL boost_637: off=%h wrap=%b want off=%h wrap=%b (off0=639)",
               layer_offset, layer_wrap, e.off, e.wr);
    end
  endtask

  task automatic test_freeze();
    exp_t e;
    layer_div = 12'h111;
    step(0, 0, 0, 1, 0);
    void'(sb.pop_front());
    for (int k = 0; k < 3; k++) begin step(1, 0, 0, 0, 0); void'(sb.pop_front()); end
    step(1, 1, 0, 0, 0);   // collision with move
    e = sb.pop_front();
    tests_run++;
    if (layer_offset !== {12'd3, 12'd3, 12'd3} || frozen !== 1'b1 || layer_offset !== e.off) begin
      tests_failed++;
      $display("FAIL freeze_enter: off=%h frz=%b want off=%h frz=1",
               layer_offset, frozen, {12'd3, 12'd3, 12'd3});
    end
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 0, 0, 0);
      e = sb.pop_front();
      tests_run++;
      if (layer_offset !== e.off || frozen !== 1'b1 || layer_wrap !== e.wr) begin
        tests_failed++;
        $display("FAIL freeze_hold[%0d]: off=%h frz=%b want off=%h frz=1",
                 k, layer_offset, frozen, e.off);
      end
    end
    step(0, 1, 1, 0, 0);   // resume blocked by collision
    e = sb.pop_front();
    tests_run++;
    if (frozen !== 1'b1 || frozen !== e.fr) begin
      tests_failed++;
      $display("FAIL resume_blocked: frz=%b want 1", frozen);
    end
    step(1, 0, 1, 0, 0);   // resume; the accompanying move is dropped
    e = sb.pop_front();
    tests_run++;
    if (frozen !== 1'b0 || layer_offset !== {12'd3, 12'd3, 12'd3} || layer_offset !== e.off) begin
      tests_failed++;
      $display("FAIL resume: frz=%b off=%h want frz=0 off=%h",
               frozen, layer_offset, {12'd3, 12'd3, 12'd3});
    end
    for (int k = 0; k < 2; k++) begin step(1, 0, 0, 0, 0); void'(sb.pop_front()); end
    tests_run++;
    if (layer_offset !== {12'd5, 12'd5, 12'd5}) begin
      tests_failed++;
      $display("FAIL resume_advance: off=%h want %h", layer_offset, {12'd5, 12'd5, 12'd5});
    end
  endtask

  task automatic test_divisors();
    exp_t e;
    step(0, 0, 0, 1, 0);
    void'(sb.pop_front());
    layer_div = 12'hF30;   // layer0=0, layer1=3, layer2=15
    for (int k = 0; k < 45; k++) begin
      step(1, 0, 0, 0, 0);
      e = sb.pop_front();
      tests_run++;
      if (layer_offset !== e.off || layer_wrap !== e.wr) begin
        tests_failed++;
        $display("FAIL div_seq[%0d]: off=%h wrap=%b want off=%h wrap=%b",
                 k, layer_offset, layer_wrap, e.off, e.wr);
      end
    end
    tests_run++;
    if (layer_offset !== {12'd3, 12'd15, 12'd0}) begin
      tests_failed++;
      $display("FAIL div_final: off=%h want %h", layer_offset, {12'd3, 12'd15, 12'd0});
    end
    step(0, 0, 0, 1, 0);
    void'(sb.pop_front());
    step(1, 0, 0, 0, 0);   // layer1 count now 1 of 3
    void'(sb.pop_front());
    layer_div = 12'hF10;   // lower layer1 divisor below the count
    step(1, 0, 0, 0, 0);
    e = sb.pop_front();
    tests_run++;
    if (layer_offset[OW +: OW] !== 12'd1 || layer_offset !== e.off) begin
      tests_failed++;
      $display("FAIL div_lowered: off1=%0d want 1", layer_offset[OW +: OW]);
    end
  endtask

  task automatic test_restart_reset();
    exp_t e;
    layer_div = 12'h111;
    for (int k = 0; k < 7; k++) begin step(1, 0, 0, 0, 0); void'(sb.pop_front()); end
    step(0, 1, 0, 0, 0);
    void'(sb.pop_front());
    step(1, 0, 0, 1, 0);   // restart while frozen
    e = sb.pop_front();
    tests_run++;
    if (layer_offset !== '0 || frozen !== 1'b0 || layer_wrap !== 3'b000 || layer_offset !== e.off) begin
      tests_failed++;
      $display("FAIL restart: off=%h frz=%b wrap=%b want all zero",
               layer_offset, frozen, layer_wrap);
    end
    for (int k = 0; k < 5; k++) begin step(1, 0, 0, 0, 0); void'(sb.pop_front()); end
    do_reset();
    e = sb.pop_front();
    tests_run++;
    if (layer_offset !== '0 || frozen !== 1'b0 || layer_wrap !== 3'b000 || layer_offset !== e.off) begin
      tests_failed++;
      $display("FAIL reset_mid: off=%h frz=%b wrap=%b want all zero",
               layer_offset, frozen, layer_wrap);
    end
    step(0, 0, 0, 0, 0);
    e = sb.pop_front();
    tests_run++;
    if (layer_wrap !== 3'b000 || layer_offset !== e.off) begin
      tests_failed++;
      $display("FAIL reset_nowrap: wrap=%b off=%h want 000 / %h", layer_wrap, layer_offset, e.off);
    end
  endtask

  initial begin
    reset = 1'b1; move = 0; collision = 0; resume = 0; restart = 0; boost = 0;
    layer_div = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_boost();
    test_freeze();
    test_divisors();
    test_restart_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
